// File: rtl/score_disp_pkg.sv
// Shared types and helpers for the score overlay.
// Glyph geometry, colour type, FSM states and sizing functions.
package score_disp_pkg;

    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;

    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // 10^n, used for the saturation limit
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // ceil(w*log10(2)) + 1 BCD nibbles for a w-bit binary value
    function automatic int bcd_nibbles(input int w);
        return (w * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/digit_font_rom.sv
// 5x7 digit font, combinational.
// Code 4'hF and out-of-range rows/cols are dark.
module digit_font_rom
    import score_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       lit
);

    logic [34:0] g;
    logic [5:0]  idx;

    // glyph lookup; row 0 is the top, bit 34 is row 0 column 0
    always_comb begin
        case (digit)
            4'd0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1: g = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3: g = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: g = '0;
        endcase
        idx = 6'(34 - (int'(row) * GLYPH_W + int'(col)));
        lit = 1'b0;
        if (int'(row) < GLYPH_H && int'(col) < GLYPH_W) lit = g[idx];
    end

endmodule

// File: rtl/score_display_gen.sv
// N-digit decimal score overlay with sequential BCD conversion
// and frame-synchronous digit update.
module score_display_gen
    import score_disp_pkg::*;
#(
    parameter int   SCORE_W  = 8,
    parameter int   DIGITS   = 3,
    parameter int   X0       = 16,
    parameter int   Y0       = 8,
    parameter int   SCALE_SH = 1,
    parameter logic [2:0] FG_COLOR = 3'b111,
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter bit   BLANK_LZ = 1'b1
) (
    input  logic               VGA_clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic               overflow,
    input  logic [9:0]         xCount,
    input  logic [8:0]         yCount,
    output color_t             color,
    output logic               pixel_on
);

    localparam int NB    = bcd_nibbles(SCORE_W);
    localparam int BW    = (NB > DIGITS) ? NB : DIGITS;
    localparam int BB    = 4 * BW;
    localparam int DB    = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int CW    = 6 << SCALE_SH;
    localparam int CH    = 7 << SCALE_SH;
    localparam logic [63:0] MAXV = 64'(pow10(DIGITS) - 1);

    state_t             state;
    logic [SCORE_W-1:0] sh;
    logic [BB-1:0]      bcd;
    logic [BB-1:0]      adj;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic [SCORE_W-1:0] pend_val;
    logic               pend_vld;
    logic [DB-1:0]      staged;
    logic               dirty;
    logic [DB-1:0]      shown;

    logic               start;
    logic [SCORE_W-1:0] start_val;
    logic               start_ovf;
    logic               frame;

    assign busy  = (state != IDLE);
    assign frame = (xCount == 10'd0) && (yCount == 9'd0);

    // a new conversion starts from IDLE, or back-to-back out of DONE
    always_comb begin
        start = 1'b0;
        if (state == IDLE && score_valid) start = 1'b1;
        if (state == DONE && (score_valid || pend_vld)) start = 1'b1;
        start_val = score;
        if (state == DONE && !score_valid) start_val = pend_val;
        start_ovf = 64'(start_val) > MAXV;
    end

    // double-dabble correction: +3 on every nibble >= 5
    always_comb begin
        adj = bcd;
        for (int k = 0; k < BW; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // conversion FSM with one-entry latest-wins pending request
    always_ff @(posedge VGA_clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            overflow <= 1'b0;
            pend_val <= '0;
            pend_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                SHIFT: begin
                    {bcd, sh} <= {adj, sh} << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SCORE_W - 1)) state <= DONE;
                    if (score_valid) begin
                        pend_val <= score;
                        pend_vld <= 1'b1;
                    end
                end
                DONE: begin
                    pend_vld <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (start) begin
                state    <= SHIFT;
                sh       <= start_val;
                bcd      <= '0;
                cnt      <= '0;
                sat      <= start_ovf;
                overflow <= start_ovf;
            end
        end
    end

    // staged result and frame-start copy into the displayed digits
    always_ff @(posedge VGA_clk) begin
        if (!rst_n) begin
            staged <= '0;
            dirty  <= 1'b0;
            shown  <= '0;
        end else begin
            if (frame && dirty) begin
                shown <= staged;
                dirty <= 1'b0;
            end
            if (state == DONE) begin
                staged <= sat ? {DIGITS{4'd9}} : bcd[DB-1:0];
                dirty  <= 1'b1;
            end
        end
    end

    logic [DIGITS-1:0][3:0] disp;
    logic                   lead;
    logic [3:0]             d;

    // per-digit codes with leading zeros replaced by the blank code
    always_comb begin
        disp = '0;
        lead = BLANK_LZ;
        d    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = shown[4*(DIGITS-1-i) +: 4];
            if (lead && d == 4'd0 && i != DIGITS - 1) begin
                disp[i] = 4'hF;
            end else begin
                disp[i] = d;
                lead    = 1'b0;
            end
        end
    end

    int         dx;
    int         dy;
    logic       hit;
    logic [3:0] cur;
    logic [2:0] frow;
    logic [2:0] fcol;
    logic [3:0] rom_digit;
    logic       lit;

    // map the pixel to a digit cell and font coordinate
    always_comb begin
        dx   = int'(xCount) - X0;
        dy   = int'(yCount) - Y0;
        hit  = 1'b0;
        cur  = 4'hF;
        fcol = '0;
        frow = 3'(dy >>> SCALE_SH);
        for (int i = 0; i < DIGITS; i++) begin
            if (dy >= 0 && dy < CH && dx >= i * CW && dx < (i + 1) * CW) begin
                hit  = 1'b1;
                cur  = disp[i];
                fcol = 3'((dx - i * CW) >>> SCALE_SH);
            end
        end
        rom_digit = hit ? cur : 4'hF;
    end

    digit_font_rom u_rom (
        .digit (rom_digit),
        .row   (frow),
        .col   (fcol),
        .lit   (lit)
    );

    // registered pixel output
    always_ff @(posedge VGA_clk) begin
        if (!rst_n) begin
            color    <= BG_COLOR;
            pixel_on <= 1'b0;
        end else begin
            color    <= lit ? FG_COLOR : BG_COLOR;
            pixel_on <= lit;
        end
    end

endmodule

// File: tb/tb_score_display_gen.sv
// Directed bench for score_display_gen: pixel vectors from a table,
// plus sequences for chaining, saturation, frame alignment and reset.
module tb_score_display_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] score1, score2;
    logic       v1, v2;
    logic       busy1, busy2, ovf1, ovf2;
    logic [9:0] xCount;
    logic [8:0] yCount;
    logic [2:0] color1, color2;
    logic       on1, on2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_display_gen u1 (
        .VGA_clk(clk), .rst_n(rst_n), .score(score1), .score_valid(v1),
        .busy(busy1), .overflow(ovf1), .xCount(xCount), .yCount(yCount),
        .color(color1), .pixel_on(on1)
    );

    score_display_gen #(.DIGITS(2)) u2 (
        .VGA_clk(clk), .rst_n(rst_n), .score(score2), .score_valid(v2),
        .busy(busy2), .overflow(ovf2), .xCount(xCount), .yCount(yCount),
        .color(color2), .pixel_on(on2)
    );

    typedef struct {
        int x;
        int y;
        bit on;
    } vec_t;

    vec_t        vt[21];
    logic [34:0] font[10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic probe(input int x, input int y);
        @(negedge clk);
        xCount = 10'(x);
        yCount = 9'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        @(negedge clk);
        xCount = 10'd600;
        yCount = 9'd400;
    endtask

    task automatic frame_start();
        probe(0, 0);
        park();
    endtask

    task automatic pulse(input int which, input int val);
        @(negedge clk);
        if (which == 1) begin score1 = 8'(val); v1 = 1'b1; end
        else begin score2 = 8'(val); v2 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic wait_idle(input int which, output int n);
        n = 0;
        while (((which == 1) ? busy1 : busy2) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic bit exp_on(input int x, input int y, input int nd,
                                  input int d0, input int d1, input int d2);
        int dx, dy, i, col, row, dg;
        logic [34:0] g;
        if (x < 16 || y < 8) return 1'b0;
        dx = x - 16;
        dy = y - 8;
        i  = dx / 12;
        if (i >= nd || dy >= 14) return 1'b0;
        col = (dx % 12) / 2;
        row = dy / 2;
        if (col >= 5) return 1'b0;
        dg = (i == 0) ? d0 : (i == 1) ? d1 : d2;
        if (dg == 15) return 1'b0;
        g = font[4'(dg)];
        return g[6'(34 - row * 5 - col)];
    endfunction

    task automatic scan(input int which, input int nd, input int d0,
                        input int d1, input int d2, input string nm);
        int  errs, fx, fy, fo, fc;
        bit  e;
        logic ao;
        logic [2:0] ac;
        errs = 0; fx = 0; fy = 0; fo = 0; fc = 0;
        for (int y = 7; y <= 23; y++) begin
            for (int x = 14; x <= 17 + nd * 12; x++) begin
                probe(x, y);
                e  = exp_on(x, y, nd, d0, d1, d2);
                ao = (which == 1) ? on1 : on2;
                ac = (which == 1) ? color1 : color2;
                if (ao !== e || ac !== (e ? 3'b111 : 3'b000)) begin
                    if (errs == 0) begin
                        fx = x; fy = y; fo = int'(ao); fc = int'(ac);
                    end
                    errs++;
                end
            end
        end
        park();
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL scan %s: %0d bad pixels, first (%0d,%0d) pixel_on=%0d color=%0d",
                     nm, errs, fx, fy, fo, fc);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi, input string nm);
        for (int k = lo; k <= hi; k++) begin
            probe(vt[k].x, vt[k].y);
            total++;
            if (on1 !== vt[k].on || color1 !== (vt[k].on ? 3'b111 : 3'b000)) begin
                bad++;
                $display("FAIL %s[%0d] (%0d,%0d): pixel_on=%0d color=%0d want on=%0d",
                         nm, k, vt[k].x, vt[k].y, on1, color1, vt[k].on);
            end
        end
        park();
    endtask

    initial begin
        int n;
        font[0] = 35'b01110_10001_10011_10101_11001_10001_01110;
        font[1] = 35'b00100_01100_00100_00100_00100_00100_01110;
        font[2] = 35'b01110_10001_00001_00010_00100_01000_11111;
        font[3] = 35'b11111_00010_00100_00010_00001_10001_01110;
        font[4] = 35'b00010_00110_01010_10010_11111_00010_00010;
        font[5] = 35'b11111_10000_11110_00001_00001_10001_01110;
        font[6] = 35'b00110_01000_10000_11110_10001_10001_01110;
        font[7] = 35'b11111_00001_00010_00100_01000_01000_01000;
        font[8] = 35'b01110_10001_10001_01110_10001_10001_01110;
        font[9] = 35'b01110_10001_10001_01111_00001_00010_01100;

        // display "  0"
        vt[0]  = '{16, 8, 1'b0};
        vt[1]  = '{40, 8, 1'b0};
        vt[2]  = '{42, 8, 1'b1};
        vt[3]  = '{44, 9, 1'b1};
        vt[4]  = '{46, 10, 1'b0};
        vt[5]  = '{48, 10, 1'b1};
        vt[6]  = '{50, 8, 1'b0};
        vt[7]  = '{52, 8, 1'b0};
        vt[8]  = '{15, 8, 1'b0};
        vt[9]  = '{42, 22, 1'b0};
        vt[10] = '{42, 21, 1'b1};
        vt[11] = '{40, 14, 1'b1};
        // display "123"
        vt[12] = '{20, 8, 1'b1};
        vt[13] = '{18, 8, 1'b0};
        vt[14] = '{22, 8, 1'b0};
        vt[15] = '{16, 21, 1'b0};
        vt[16] = '{18, 21, 1'b1};
        vt[17] = '{28, 8, 1'b0};
        vt[18] = '{30, 8, 1'b1};
        vt[19] = '{40, 8, 1'b1};
        vt[20] = '{50, 8, 1'b0};

        rst_n  = 1'b0;
        v1     = 1'b0;
        v2     = 1'b0;
        score1 = '0;
        score2 = '0;
        xCount = 10'd600;
        yCount = 9'd400;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy1), 0);
        chk("reset overflow", int'(ovf1), 0);
        chk("reset color", int'(color1), 0);
        chk("reset pixel_on", int'(on1), 0);
        chk("reset busy2", int'(busy2), 0);
        rst_n = 1'b1;

        // 1: reset value "0"
        frame_start();
        run_vecs(0, 11, "zero");
        scan(1, 3, 15, 15, 0, "zero");

        // 2: 123, busy length, frame-synchronous update
        pulse(1, 123);
        wait_idle(1, n);
        chk("busy cycles 123", n, 9);
        scan(1, 3, 15, 15, 0, "held before frame");
        frame_start();
        run_vecs(12, 20, "123");
        scan(1, 3, 1, 2, 3, "123");

        // 3: second request while busy is chained, latest shown
        pulse(1, 45);
        pulse(1, 67);
        wait_idle(1, n);
        chk("chained busy cycles", n, 16);
        frame_start();
        scan(1, 3, 15, 6, 7, "67");
        chk("overflow 67", int'(ovf1), 0);

        // 4: two-digit saturation and recovery
        pulse(2, 150);
        wait_idle(2, n);
        chk("busy cycles 150", n, 9);
        chk("overflow 150", int'(ovf2), 1);
        frame_start();
        scan(2, 2, 9, 9, 0, "99");
        pulse(2, 7);
        wait_idle(2, n);
        chk("overflow 7", int'(ovf2), 0);
        frame_start();
        scan(2, 2, 15, 7, 0, " 7");

        // 5: DONE on the frame-start cycle
        pulse(1, 89);
        repeat (8) @(negedge clk);
        chk("in DONE", int'(busy1), 1);
        xCount = 10'd0;
        yCount = 9'd0;
        @(negedge clk);
        chk("DONE aligned", int'(busy1), 0);
        xCount = 10'd600;
        yCount = 9'd400;
        scan(1, 3, 15, 6, 7, "old held");
        frame_start();
        scan(1, 3, 15, 8, 9, "89");

        // 6: reset mid-conversion
        pulse(1, 200);
        repeat (3) @(negedge clk);
        chk("mid shift busy", int'(busy1), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("post reset busy", int'(busy1), 0);
        chk("post reset overflow", int'(ovf1), 0);
        repeat (20) @(negedge clk);
        chk("stays idle", int'(busy1), 0);
        frame_start();
        scan(1, 3, 15, 15, 0, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
